// File: rtl/instruction_loader_if.sv
// Host byte stream and instruction-memory write port seen by the loader.
// The loader takes the slave side; the host/memory side takes master.
interface instruction_loader_if #(
    parameter int PC_WIDTH          = 9,
    parameter int INSTRUCTION_WIDTH = 16
);
    logic                         byte_valid_i;
    logic [7:0]                   byte_i;
    logic                         byte_ready_o;
    logic                         mem_we_o;
    logic [PC_WIDTH-1:0]          mem_addr_o;
    logic [INSTRUCTION_WIDTH-1:0] mem_wdata_o;

    modport master (
        output byte_valid_i, byte_i,
        input  byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        input  byte_valid_i, byte_i,
        output byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/instruction_loader.sv
// Assembles little-endian byte pairs into 16-bit instructions, validates the
// encoding and writes good words sequentially into instruction memory.
module instruction_loader #(
    parameter int PC_WIDTH          = 9,
    parameter int INSTRUCTION_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [PC_WIDTH:0]       length_i,
    instruction_loader_if.slave     bus,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [1:0]              error_code_o,
    output logic [PC_WIDTH:0]       count_o
);
    typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_WRITE, S_DONE} state_t;

    localparam logic [2:0] T_ACCEPT    = 3'd0;
    localparam logic [2:0] T_SPLIT     = 3'd1;
    localparam logic [2:0] T_MATCH     = 3'd2;
    localparam logic [2:0] T_JMP       = 3'd3;
    localparam logic [2:0] T_END       = 3'd4;
    localparam logic [2:0] T_MATCH_ANY = 3'd5;
    localparam logic [2:0] T_ACC_PART  = 3'd6;
    localparam logic [2:0] T_NOT_MATCH = 3'd7;

    localparam logic [PC_WIDTH:0] MAX_LEN = {1'b1, {PC_WIDTH{1'b0}}};

    state_t                       state_q, state_d;
    logic [INSTRUCTION_WIDTH-1:0] word_q, word_d;
    logic [PC_WIDTH:0]            len_q, len_d;
    logic [PC_WIDTH:0]            count_q, count_d;
    logic                         error_q, error_d;
    logic [1:0]                   code_q, code_d;
    logic [INSTRUCTION_WIDTH-1:0] hi_word;
    logic [1:0]                   chk_code;

    // Word as it would be once the current high byte is accepted.
    always_comb begin
        hi_word  = {bus.byte_i, word_q[7:0]};
        chk_code = 2'd0;
        case (hi_word[15:13])
            T_SPLIT, T_JMP:
                if (32'(hi_word[12:0]) >= 32'(len_q)) chk_code = 2'd1;
            T_MATCH, T_NOT_MATCH, T_MATCH_ANY:
                if (hi_word[12:8] != 5'd0) chk_code = 2'd2;
            T_ACCEPT, T_ACC_PART, T_END:
                if (hi_word[12:0] != 13'd0) chk_code = 2'd2;
            default: chk_code = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        len_d   = len_q;
        count_d = count_q;
        error_d = error_q;
        code_d  = code_q;
        if (abort_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    count_d = '0;
                    error_d = 1'b0;
                    code_d  = 2'd0;
                    if (length_i != '0 && length_i <= MAX_LEN) begin
                        len_d   = length_i;
                        state_d = S_LOW;
                    end else begin
                        error_d = 1'b1;
                        code_d  = 2'd3;
                        state_d = S_DONE;
                    end
                end
                S_LOW: if (bus.byte_valid_i) begin
                    word_d[7:0] = bus.byte_i;
                    state_d     = S_HIGH;
                end
                S_HIGH: if (bus.byte_valid_i) begin
                    // A failing word is dropped before it ever reaches WRITE.
                    if (chk_code != 2'd0) begin
                        error_d = 1'b1;
                        code_d  = chk_code;
                        state_d = S_DONE;
                    end else begin
                        word_d  = hi_word;
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    count_d = count_q + 1'b1;
                    state_d = (count_d == len_q) ? S_DONE : S_LOW;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            error_q <= 1'b0;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            len_q   <= len_d;
            count_q <= count_d;
            error_q <= error_d;
            code_q  <= code_d;
        end
    end

    // abort_i gates the strobes so a cancelled cycle neither writes nor signals done.
    assign bus.byte_ready_o = (state_q == S_LOW) || (state_q == S_HIGH);
    assign bus.mem_we_o     = (state_q == S_WRITE) && !abort_i;
    assign bus.mem_addr_o   = count_q[PC_WIDTH-1:0];
    assign bus.mem_wdata_o  = word_q;
    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = (state_q == S_DONE) && !abort_i;
    assign error_o          = error_q;
    assign error_code_o     = code_q;
    assign count_o          = count_q;
endmodule

// File: tb/tb_instruction_loader.sv
// Randomized scoreboard bench for instruction_loader: a spec-level model queues
// expected writes and done results; a negedge monitor pops and compares them.
module tb_instruction_loader;
    localparam int PCW = 9;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_i = 1'b0;
    logic           abort_i = 1'b0;
    logic [PCW:0]   length_i = '0;
    logic           busy_o, done_o, error_o;
    logic [1:0]     error_code_o;
    logic [PCW:0]   count_o;

    instruction_loader_if #(.PC_WIDTH(PCW)) bus ();

    instruction_loader #(.PC_WIDTH(PCW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .length_i(length_i), .bus(bus), .busy_o(busy_o), .done_o(done_o),
        .error_o(error_o), .error_code_o(error_code_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; logic [15:0] data; } wr_t;
    typedef struct { int err; int code; int count; } dn_t;

    wr_t wq[$];
    dn_t dq[$];
    int  n_cmp = 0;
    int  n_fail = 0;

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endfunction

    function automatic void fail_evt(string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: unexpected or missing event at %0t", nm, $time);
    endfunction

    // Scoreboard monitor: every write strobe and done pulse must match the next expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_we_o) begin
                if (wq.size() == 0) fail_evt("unexpected_write");
                else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_addr", int'(bus.mem_addr_o), e.addr);
                    chk("wr_data", int'(bus.mem_wdata_o), int'(e.data));
                end
            end
            if (done_o) begin
                if (dq.size() == 0) fail_evt("unexpected_done");
                else begin
                    dn_t d;
                    d = dq.pop_front();
                    chk("done_err", int'(error_o), d.err);
                    chk("done_code", int'(error_code_o), d.code);
                    chk("done_count", int'(count_o), d.count);
                end
            end
        end
    end

    // Reference: walk the program, stop at the first illegal word.
    task automatic model(input int len, input logic [15:0] w[$], output int n_send);
        int code;
        logic [2:0] t;
        if (len == 0 || len > (1 << PCW)) begin
            dq.push_back('{1, 3, 0});
            n_send = 0;
            return;
        end
        for (int i = 0; i < len; i++) begin
            t = w[i][15:13];
            if (t == 3'd1 || t == 3'd3)
                code = (int'(w[i][12:0]) >= len) ? 1 : 0;
            else if (t == 3'd2 || t == 3'd5 || t == 3'd7)
                code = (w[i][12:8] != 5'd0) ? 2 : 0;
            else
                code = (w[i][12:0] != 13'd0) ? 2 : 0;
            if (code != 0) begin
                dq.push_back('{1, code, i});
                n_send = i + 1;
                return;
            end
            wq.push_back('{i, w[i]});
        end
        dq.push_back('{0, 0, len});
        n_send = len;
    endtask

    function automatic logic [15:0] rand_word(int len);
        logic [2:0]  t;
        logic [12:0] d;
        bit          bad;
        t   = 3'($urandom_range(0, 7));
        bad = ($urandom_range(0, 9) == 0);
        case (t)
            3'd1, 3'd3:       d = bad ? 13'(len + $urandom_range(0, 3)) : 13'($urandom_range(0, len - 1));
            3'd2, 3'd5, 3'd7: d = {bad ? 5'($urandom_range(1, 31)) : 5'd0, 8'($urandom)};
            default:          d = bad ? 13'($urandom_range(1, 8191)) : 13'd0;
        endcase
        return {t, d};
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int g;
        bit hs;
        int budget;
        g = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (g) begin
            bus.byte_valid_i = 1'b0;
            bus.byte_i = 8'($urandom);
            @(negedge clk);
        end
        bus.byte_valid_i = 1'b1;
        bus.byte_i = b;
        hs = 1'b0;
        budget = 0;
        while (!hs && budget < 30) begin
            hs = bus.byte_ready_o;
            @(negedge clk);
            budget++;
        end
        if (!hs) fail_evt("byte_timeout");
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (busy_o && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (busy_o) fail_evt("idle_timeout");
    endtask

    task automatic check_drained(string nm);
        chk({nm, "_left_wr"}, wq.size(), 0);
        chk({nm, "_left_done"}, dq.size(), 0);
        wq.delete();
        dq.delete();
    endtask

    // Start is issued at the current negedge, so loads can run back to back.
    task automatic run_load(input int len, input logic [15:0] w[$], input int gap);
        int n;
        model(len, w, n);
        start_i = 1'b1;
        length_i = len[PCW:0];
        @(negedge clk);
        start_i = 1'b0;
        length_i = 10'($urandom);
        if (len == 0 || len > (1 << PCW)) begin
            chk("badlen_ready", int'(bus.byte_ready_o), 0);
            chk("badlen_done_t1", int'(done_o), 1);
        end else begin
            chk("start_busy_t1", int'(busy_o), 1);
            chk("start_ready_t1", int'(bus.byte_ready_o), 1);
        end
        for (int i = 0; i < n; i++) begin
            send_byte(w[i][7:0], gap);
            send_byte(w[i][15:8], gap);
        end
        bus.byte_valid_i = 1'b0;
        wait_idle();
    endtask

    initial begin
        logic [15:0] w[$];
        int len;
        bus.byte_valid_i = 1'b0;
        bus.byte_i = 8'h00;

        #12;
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_ready", int'(bus.byte_ready_o), 0);
        chk("rst_we", int'(bus.mem_we_o), 0);
        chk("rst_addr", int'(bus.mem_addr_o), 0);
        chk("rst_wdata", int'(bus.mem_wdata_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_err", int'(error_o), 0);
        chk("rst_code", int'(error_code_o), 0);
        chk("rst_count", int'(count_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        w = '{16'h4061, 16'h6000, 16'h0000};
        run_load(3, w, 0);
        check_drained("basic");

        w = '{16'h2005, 16'h0000};
        run_load(2, w, 0);
        check_drained("range");

        w = '{16'h4161};
        run_load(1, w, 0);
        w = '{16'h0000};
        run_load(1, w, 0);
        chk("err_cleared", int'(error_o), 0);
        check_drained("reserved");

        w = {};
        run_load(0, w, 0);
        run_load(600, w, 0);
        check_drained("badlen");

        w = {};
        for (int i = 0; i < 512; i++) w.push_back(16'h0000);
        run_load(512, w, 0);
        check_drained("full");

        w = '{16'h4061, 16'h6000, 16'h0000};
        run_load(3, w, 1);
        check_drained("backpressure");

        for (int k = 0; k < 30; k++) begin
            len = $urandom_range(1, 8);
            w = {};
            for (int i = 0; i < len; i++) w.push_back(rand_word(len));
            run_load(len, w, 2);
        end
        check_drained("random");

        // Abort while the second instruction's high byte is pending.
        wq.push_back('{0, 16'h0000});
        start_i = 1'b1;
        length_i = 10'd3;
        @(negedge clk);
        start_i = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        abort_i = 1'b1;
        bus.byte_valid_i = 1'b1;
        bus.byte_i = 8'h00;
        @(negedge clk);
        abort_i = 1'b0;
        bus.byte_valid_i = 1'b0;
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_count", int'(count_o), 1);
        chk("abort_err", int'(error_o), 0);
        repeat (3) @(negedge clk);
        check_drained("abort");

        // Asynchronous reset in the middle of a load.
        wq.push_back('{0, 16'h4061});
        start_i = 1'b1;
        length_i = 10'd3;
        @(negedge clk);
        start_i = 1'b0;
        send_byte(8'h61, 0);
        send_byte(8'h40, 0);
        send_byte(8'h00, 0);
        bus.byte_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy_o), 0);
        chk("mid_rst_ready", int'(bus.byte_ready_o), 0);
        chk("mid_rst_we", int'(bus.mem_we_o), 0);
        chk("mid_rst_addr", int'(bus.mem_addr_o), 0);
        chk("mid_rst_wdata", int'(bus.mem_wdata_o), 0);
        chk("mid_rst_count", int'(count_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_drained("reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
